// File: rtl/sdr_ch3_arbiter_if.sv
// SDRAM channel 3 sharing bus: ROM loader write port, BG2 read port and the
// downstream controller port, bundled so the arbiter has a single bus port.
interface sdr_ch3_arbiter_if #(
  parameter int AW = 25,
  parameter int DW = 16
);
  logic          rom_mode;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_din;
  logic [1:0]    rom_be;
  logic          rom_req;
  logic          rom_rdy;

  logic [AW-1:0] bg_addr;
  logic          bg_req;
  logic [DW-1:0] bg_dout;
  logic          bg_rdy;

  logic [AW-1:0] dn_addr;
  logic [DW-1:0] dn_din;
  logic [1:0]    dn_be;
  logic          dn_rnw;
  logic          dn_req;
  logic [DW-1:0] dn_dout;
  logic          dn_rdy;

  logic          timeout_err;

  // Arbiter side.
  modport slave (
    input  rom_mode, rom_addr, rom_din, rom_be, rom_req,
    input  bg_addr, bg_req,
    input  dn_dout, dn_rdy,
    output rom_rdy, bg_dout, bg_rdy,
    output dn_addr, dn_din, dn_be, dn_rnw, dn_req,
    output timeout_err
  );

  // Requesters plus SDRAM controller side.
  modport master (
    output rom_mode, rom_addr, rom_din, rom_be, rom_req,
    output bg_addr, bg_req,
    output dn_dout, dn_rdy,
    input  rom_rdy, bg_dout, bg_rdy,
    input  dn_addr, dn_din, dn_be, dn_rnw, dn_req,
    input  timeout_err
  );
endinterface

// File: rtl/sdr_ch3_arbiter.sv
// Registered owner arbiter for SDRAM channel 3: ROM loader writes vs BG2 reads,
// never switching owner mid-access, with a watchdog against a lost dn_rdy.
module sdr_ch3_arbiter #(
  parameter int AW      = 25,
  parameter int DW      = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              RSTn,
  sdr_ch3_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ROM_XFER = 2'd1,
    BG_XFER  = 2'd2,
    BG_STUB  = 2'd3
  } state_t;

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

  state_t        state_q, state_d;
  logic [AW-1:0] dn_addr_q, dn_addr_d;
  logic [DW-1:0] dn_din_q, dn_din_d;
  logic [1:0]    dn_be_q, dn_be_d;
  logic          dn_rnw_q, dn_rnw_d;
  logic          dn_req_q, dn_req_d;
  logic          rom_rdy_q, rom_rdy_d;
  logic          bg_rdy_q, bg_rdy_d;
  logic [DW-1:0] bg_dout_q, bg_dout_d;
  logic          timeout_err_q, timeout_err_d;
  logic [7:0]    wd_q, wd_d;

  logic rom_go;
  logic bg_go;
  logic wd_expired;

  // A requester still holds req in the cycle after its rdy pulse; mask it then
  // so the same request is never granted twice.
  assign rom_go     = bus.rom_mode && bus.rom_req && !rom_rdy_q;
  assign bg_go      = bus.bg_req && !bg_rdy_q;
  assign wd_expired = (wd_q == WD_LIMIT);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves a
    // signal unassigned; that is what keeps this block from inferring latches.
    state_d       = state_q;
    dn_addr_d     = dn_addr_q;
    dn_din_d      = dn_din_q;
    dn_be_d       = dn_be_q;
    dn_rnw_d      = dn_rnw_q;
    dn_req_d      = dn_req_q;
    rom_rdy_d     = 1'b0;
    bg_rdy_d      = 1'b0;
    bg_dout_d     = bg_dout_q;
    timeout_err_d = timeout_err_q;
    wd_d          = wd_q;

    unique case (state_q)
      IDLE: begin
        if (rom_go) begin
          state_d   = ROM_XFER;
          dn_addr_d = bus.rom_addr;
          dn_din_d  = bus.rom_din;
          dn_be_d   = bus.rom_be;
          dn_rnw_d  = 1'b0;
          dn_req_d  = 1'b1;
          wd_d      = '0;
        end else if (bg_go && !bus.rom_mode) begin
          state_d   = BG_XFER;
          dn_addr_d = bus.bg_addr;
          dn_rnw_d  = 1'b1;
          dn_req_d  = 1'b1;
          wd_d      = '0;
        end else if (bg_go) begin
          state_d   = BG_STUB;
        end
      end

      ROM_XFER: begin
        // A dn_rdy coinciding with expiry is a normal completion.
        if (bus.dn_rdy) begin
          state_d   = IDLE;
          dn_req_d  = 1'b0;
          rom_rdy_d = 1'b1;
        end else if (wd_expired) begin
          state_d       = IDLE;
          dn_req_d      = 1'b0;
          rom_rdy_d     = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end

      BG_XFER: begin
        if (bus.dn_rdy) begin
          state_d   = IDLE;
          dn_req_d  = 1'b0;
          bg_dout_d = bus.dn_dout;
          bg_rdy_d  = 1'b1;
        end else if (wd_expired) begin
          state_d       = IDLE;
          dn_req_d      = 1'b0;
          bg_dout_d     = '0;
          bg_rdy_d      = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end

      BG_STUB: begin
        // Keeps the BG2 pipeline moving during download without an SDRAM read.
        state_d   = IDLE;
        bg_dout_d = '0;
        bg_rdy_d  = 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state_q       <= IDLE;
      dn_addr_q     <= '0;
      dn_din_q      <= '0;
      dn_be_q       <= '0;
      dn_rnw_q      <= 1'b1;
      dn_req_q      <= 1'b0;
      rom_rdy_q     <= 1'b0;
      bg_rdy_q      <= 1'b0;
      bg_dout_q     <= '0;
      timeout_err_q <= 1'b0;
      wd_q          <= '0;
    end else begin
      state_q       <= state_d;
      dn_addr_q     <= dn_addr_d;
      dn_din_q      <= dn_din_d;
      dn_be_q       <= dn_be_d;
      dn_rnw_q      <= dn_rnw_d;
      dn_req_q      <= dn_req_d;
      rom_rdy_q     <= rom_rdy_d;
      bg_rdy_q      <= bg_rdy_d;
      bg_dout_q     <= bg_dout_d;
      timeout_err_q <= timeout_err_d;
      wd_q          <= wd_d;
    end
  end

  assign bus.dn_addr     = dn_addr_q;
  assign bus.dn_din      = dn_din_q;
  assign bus.dn_be       = dn_be_q;
  assign bus.dn_rnw      = dn_rnw_q;
  assign bus.dn_req      = dn_req_q;
  assign bus.rom_rdy     = rom_rdy_q;
  assign bus.bg_rdy      = bg_rdy_q;
  assign bus.bg_dout     = bg_dout_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sdr_ch3_arbiter.sv
// Bench for sdr_ch3_arbiter: table of transactions with a scoreboard of expected
// SDRAM requests and rdy responses, plus hand sequences for stray/timeout/reset.
module tb_sdr_ch3_arbiter;
  localparam int AW = 25;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic RSTn;
  always #5 clk = ~clk;

  sdr_ch3_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sdr_ch3_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(255)) dut (
    .clk  (clk),
    .RSTn (RSTn),
    .bus  (bus)
  );

  typedef struct {
    bit            rom_mode;
    bit            rom_req;
    bit            bg_req;
    bit            drop_mode;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] din;
    logic [1:0]    be;
    logic [AW-1:0] bg_addr;
    int            lat;      // 0 = controller never answers
    logic [DW-1:0] rd;
  } vec_t;

  typedef struct {
    bit            rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [1:0]    be;
  } dn_exp_t;

  typedef struct {
    bit            is_bg;
    logic [DW-1:0] data;
  } rsp_exp_t;

  dn_exp_t  dn_q[$];
  rsp_exp_t rsp_q[$];

  int            tests = 0;
  int            fails = 0;
  int            resp_lat = 0;
  logic [DW-1:0] resp_data = '0;
  int            req_len = 0;
  int            last_req_len = 0;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the arbiter must issue downstream and answer upstream.
  task automatic expect_vec(input vec_t v);
    dn_exp_t  d;
    rsp_exp_t r;
    if (v.rom_mode && v.rom_req) begin
      d.rnw = 1'b0; d.addr = v.rom_addr; d.din = v.din; d.be = v.be;
      dn_q.push_back(d);
      r.is_bg = 1'b0; r.data = '0;
      rsp_q.push_back(r);
    end
    if (v.bg_req) begin
      r.is_bg = 1'b1;
      if (v.rom_mode) begin
        r.data = '0;
      end else begin
        d.rnw = 1'b1; d.addr = v.bg_addr; d.din = '0; d.be = '0;
        dn_q.push_back(d);
        r.data = (v.lat == 0) ? '0 : v.rd;
      end
      rsp_q.push_back(r);
    end
  endtask

  task automatic run_vec(input vec_t v);
    bit rom_pend, bg_pend, rs, bs;
    expect_vec(v);
    @(posedge clk); #1;
    bus.rom_mode = v.rom_mode;
    bus.rom_addr = v.rom_addr;
    bus.rom_din  = v.din;
    bus.rom_be   = v.be;
    bus.bg_addr  = v.bg_addr;
    bus.rom_req  = v.rom_req;
    bus.bg_req   = v.bg_req;
    resp_lat     = v.lat;
    resp_data    = v.rd;
    rom_pend     = v.rom_req;
    bg_pend      = v.bg_req;
    for (int c = 0; c < 1000 && (rom_pend || bg_pend); c++) begin
      @(negedge clk);
      rs = bus.rom_rdy;
      bs = bus.bg_rdy;
      @(posedge clk); #1;
      if (rs) begin bus.rom_req = 1'b0; rom_pend = 1'b0; end
      if (bs) begin bus.bg_req  = 1'b0; bg_pend  = 1'b0; end
      if (v.drop_mode && bus.dn_req) bus.rom_mode = 1'b0;
    end
    check("rdy_wait_expired", {30'd0, rom_pend, bg_pend}, 32'd0);
    bus.rom_req = 1'b0;
    bus.bg_req  = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // SDRAM controller model: answers dn_req after resp_lat cycles.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      bus.dn_rdy = 1'b0;
      if (bus.dn_req && resp_lat > 0) begin
        cnt++;
        if (cnt == resp_lat) begin
          bus.dn_rdy  = 1'b1;
          bus.dn_dout = resp_data;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares each new dn_req and each rdy pulse against the scoreboard.
  initial begin
    bit       prev_req, prev_rr, prev_br;
    dn_exp_t  e;
    rsp_exp_t r;
    prev_req = 1'b0; prev_rr = 1'b0; prev_br = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.dn_req) req_len = prev_req ? req_len + 1 : 1;
      if (!bus.dn_req && prev_req) last_req_len = req_len;
      if (bus.dn_req && !prev_req) begin
        if (dn_q.size() == 0) begin
          check("unexpected_dn_req", 32'(bus.dn_addr), 32'hFFFF_FFFF);
        end else begin
          e = dn_q.pop_front();
          check("dn_rnw", 32'(bus.dn_rnw), 32'(e.rnw));
          check("dn_addr", 32'(bus.dn_addr), 32'(e.addr));
          if (!e.rnw) begin
            check("dn_din", 32'(bus.dn_din), 32'(e.din));
            check("dn_be", 32'(bus.dn_be), 32'(e.be));
          end
        end
      end
      if (bus.rom_rdy) begin
        check("rom_rdy_single", 32'(prev_rr), 32'd0);
        if (rsp_q.size() == 0) begin
          check("unexpected_rom_rdy", 32'(bus.rom_rdy), 32'd0);
        end else begin
          r = rsp_q.pop_front();
          check("rom_rdy_owner", 32'd0, 32'(r.is_bg));
        end
      end
      if (bus.bg_rdy) begin
        check("bg_rdy_single", 32'(prev_br), 32'd0);
        if (rsp_q.size() == 0) begin
          check("unexpected_bg_rdy", 32'(bus.bg_rdy), 32'd0);
        end else begin
          r = rsp_q.pop_front();
          check("bg_rdy_owner", 32'd1, 32'(r.is_bg));
          check("bg_dout", 32'(bus.bg_dout), 32'(r.data));
        end
      end
      prev_req = bus.dn_req;
      prev_rr  = bus.rom_rdy;
      prev_br  = bus.bg_rdy;
    end
  end

  initial begin
    vec_t v;
    //          mode rreq breq drop rom_addr   din       be     bg_addr        lat  rd
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 25'h0,    16'h0,    2'b00, 25'h1000,    5,   16'hBEEF};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 25'h20,   16'h1234, 2'b11, 25'h0,       3,   16'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 25'h40,   16'hA5A5, 2'b01, 25'h2000,    4,   16'h9999};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 25'h0,    16'h0,    2'b00, 25'h2400,    2,   16'h7777};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 25'h60,   16'h55AA, 2'b10, 25'h0,       6,   16'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 25'h0,    16'h0,    2'b00, 25'h1FFFFFE, 1,   16'h0001};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 25'h0,    16'h0,    2'b00, 25'h3000,    255, 16'hC0DE};

    RSTn = 1'b0;
    bus.rom_mode = 1'b0; bus.rom_addr = '0; bus.rom_din = '0; bus.rom_be = '0;
    bus.rom_req = 1'b0; bus.bg_addr = '0; bus.bg_req = 1'b0;
    bus.dn_dout = '0; bus.dn_rdy = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_dn_req", 32'(bus.dn_req), 32'd0);
    check("rst_dn_rnw", 32'(bus.dn_rnw), 32'd1);
    check("rst_rdys", {30'd0, bus.rom_rdy, bus.bg_rdy}, 32'd0);
    check("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
    check("rst_bg_dout", 32'(bus.bg_dout), 32'd0);
    check("rst_dn_addr", 32'(bus.dn_addr), 32'd0);
    check("rst_dn_din_be", {14'd0, bus.dn_be, bus.dn_din}, 32'd0);
    @(posedge clk); #2 RSTn = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);
    check("no_err_at_boundary", 32'(bus.timeout_err), 32'd0);

    // Stray dn_rdy in IDLE must not disturb anything.
    @(posedge clk); #3;
    bus.dn_rdy = 1'b1; bus.dn_dout = 16'hDEAD;
    repeat (2) begin
      @(negedge clk);
      check("stray_bg_dout_held", 32'(bus.bg_dout), 32'hC0DE);
      check("stray_no_req", 32'(bus.dn_req), 32'd0);
    end

    // Lost dn_rdy: watchdog aborts the read.
    v = vecs[0]; v.bg_addr = 25'h4000; v.lat = 0;
    run_vec(v);
    check("timeout_err_set", 32'(bus.timeout_err), 32'd1);
    check("timeout_len_in_range", 32'(last_req_len >= 255 && last_req_len <= 257), 32'd1);

    v = vecs[0]; v.bg_addr = 25'h4400; v.lat = 3; v.rd = 16'h4242;
    run_vec(v);
    check("timeout_err_sticky", 32'(bus.timeout_err), 32'd1);

    // Reset mid BG_XFER: async drop of dn_req, no bg_rdy, normal service after.
    begin
      dn_exp_t d;
      d.rnw = 1'b1; d.addr = 25'h5000; d.din = '0; d.be = '0;
      dn_q.push_back(d);
    end
    @(posedge clk); #1;
    resp_lat = 0; bus.rom_mode = 1'b0; bus.bg_addr = 25'h5000; bus.bg_req = 1'b1;
    repeat (5) @(posedge clk);
    check("pre_rst_dn_req", 32'(bus.dn_req), 32'd1);
    #2 RSTn = 1'b0;
    #1;
    check("async_rst_dn_req", 32'(bus.dn_req), 32'd0);
    check("async_rst_err_clr", 32'(bus.timeout_err), 32'd0);
    check("async_rst_rnw", 32'(bus.dn_rnw), 32'd1);
    bus.bg_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_no_bg_rdy", 32'(bus.bg_rdy), 32'd0);
    end
    @(posedge clk); #2 RSTn = 1'b1;

    v = vecs[0]; v.bg_addr = 25'h6000; v.lat = 2; v.rd = 16'h1357;
    run_vec(v);
    check("dn_q_drained", dn_q.size(), 32'd0);
    check("rsp_q_drained", rsp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1, "time limit");
  end

endmodule
